// File: rtl/dense_pkg.sv
// Shared constants, FSM encoding and sizing helper for the time-multiplexed dense layer.
package dense_pkg;

    localparam int unsigned ACT_LINEAR = 0;
    localparam int unsigned ACT_RELU   = 1;
    localparam int unsigned ACT_HSIG   = 2;
    localparam int unsigned ACT_HTANH  = 3;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ACT   = 3'd3,
        ST_EMIT  = 3'd4
    } state_t;

    // Bits needed to hold v distinct values; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dense_act.sv
// Rescales the accumulator to Q(DW-FRAC).FRAC, saturates to DW signed and applies the activation.
module dense_act
    import dense_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACC_W = 38,
    parameter int unsigned ACT   = ACT_LINEAR
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [DW-1:0]    res,
    output logic                    sat
);

    localparam int unsigned XW = DW + 2;
    localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_LO  = ~SAT_HI;
    localparam logic signed [XW-1:0]    ONE     = XW'(64'd1 << FRAC);
    localparam logic signed [XW-1:0]    HALF    = XW'(64'd1 << (FRAC - 1));
    localparam logic signed [XW-1:0]    NEG_ONE = -ONE;

    logic signed [ACC_W-1:0] shifted;
    logic signed [DW-1:0]    clipped;
    logic signed [XW-1:0]    wide;
    logic signed [XW-1:0]    act_v;

    always_comb begin
        shifted = acc >>> FRAC;
        sat     = 1'b0;
        clipped = DW'(shifted);
        if (shifted > SAT_HI) begin
            clipped = DW'(SAT_HI);
            sat     = 1'b1;
        end else if (shifted < SAT_LO) begin
            clipped = DW'(SAT_LO);
            sat     = 1'b1;
        end

        // Two guard bits keep the hard-sigmoid offset and clamps free of wrap.
        wide  = XW'(clipped);
        act_v = wide;
        if (ACT == ACT_RELU) begin
            if (wide[XW-1]) act_v = '0;
        end else if (ACT == ACT_HSIG) begin
            act_v = (wide >>> 2) + HALF;
            if (act_v[XW-1])     act_v = '0;
            else if (act_v > ONE) act_v = ONE;
        end else if (ACT == ACT_HTANH) begin
            if (wide < NEG_ONE)  act_v = NEG_ONE;
            else if (wide > ONE) act_v = ONE;
        end
        res = DW'(act_v);
    end

endmodule

// File: rtl/dense_serial.sv
// Serial fixed-point dense layer: buffers one input vector, then computes each output with one MAC.
module dense_serial
    import dense_pkg::*;
#(
    parameter int unsigned N_IN  = 42,
    parameter int unsigned N_OUT = 24,
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACT   = ACT_LINEAR,
    parameter int unsigned AW    = clog2(N_OUT * (N_IN + 1))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          w_rd,
    output logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic          busy,
    output logic          ovf
);

    localparam int unsigned KW    = clog2(N_IN);
    localparam int unsigned IW    = clog2(N_IN + 1);
    localparam int unsigned OW    = clog2(N_OUT);
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned ACC_W = PW + clog2(N_IN + 1);

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [IW-1:0]           i_q, i_d;
    logic [OW-1:0]           o_q, o_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DW-1:0]           in_buf_q [N_IN];
    logic [DW-1:0]           in_buf_d [N_IN];
    logic                    pend_q, pend_d;
    logic [IW-1:0]           pend_idx_q, pend_idx_d;
    logic                    w_rd_q, w_rd_d;
    logic [AW-1:0]           w_addr_q, w_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic [DW-1:0]           out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] term;
    logic [DW-1:0]           act_res;
    logic                    act_sat;

    // ROM data returns one cycle after the read, so the term uses the index of last cycle's read.
    always_comb begin
        prod = PW'($signed(in_buf_q[KW'(pend_idx_q)])) * PW'($signed(w_data));
        if (pend_idx_q == IW'(N_IN)) term = ACC_W'($signed(w_data)) <<< FRAC;
        else                         term = ACC_W'(prod);
    end

    dense_act #(
        .DW   (DW),
        .FRAC (FRAC),
        .ACC_W(ACC_W),
        .ACT  (ACT)
    ) u_act (
        .acc(acc_q),
        .res(act_res),
        .sat(act_sat)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        i_d        = i_q;
        o_d        = o_q;
        acc_d      = acc_q;
        in_buf_d   = in_buf_q;
        pend_d     = 1'b0;
        pend_idx_d = i_q;
        w_addr_d   = w_addr_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        ovf_d      = ovf_q;

        if (pend_q) acc_d = acc_q + term;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    in_buf_d[k_q] = in_data;
                    if (k_q == KW'(N_IN - 1)) begin
                        k_d      = '0;
                        i_d      = '0;
                        o_d      = '0;
                        acc_d    = '0;
                        w_addr_d = '0;
                        state_d  = ST_MAC;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_MAC: begin
                pend_d = 1'b1;
                if (i_q == IW'(N_IN)) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d      = i_q + IW'(1);
                    w_addr_d = w_addr_q + AW'(1);
                end
            end
            ST_DRAIN: state_d = ST_ACT;
            ST_ACT: begin
                out_data_d = act_res;
                out_last_d = (o_q == OW'(N_OUT - 1));
                ovf_d      = ovf_q | act_sat;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (o_q == OW'(N_OUT - 1)) begin
                        state_d = ST_LOAD;
                    end else begin
                        o_d      = o_q + OW'(1);
                        i_d      = '0;
                        acc_d    = '0;
                        // Rows are contiguous in the ROM, so the next row follows the last bias.
                        w_addr_d = w_addr_q + AW'(1);
                        state_d  = ST_MAC;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase

        w_rd_d      = (state_d == ST_MAC);
        out_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d != ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            k_q         <= '0;
            i_q         <= '0;
            o_q         <= '0;
            acc_q       <= '0;
            in_buf_q    <= '{default: '0};
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            w_rd_q      <= 1'b0;
            w_addr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            i_q         <= i_d;
            o_q         <= o_d;
            acc_q       <= acc_d;
            in_buf_q    <= in_buf_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            w_rd_q      <= w_rd_d;
            w_addr_q    <= w_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign w_rd      = w_rd_q;
    assign w_addr    = w_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dense_serial.sv
// Drives four dense_serial instances (one per activation mode) in lockstep against a behavioural model.
module tb_dense_serial;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned FRAC  = 8;
    localparam int unsigned AW    = 4;
    localparam int          NM    = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready  [NM];
    logic          out_valid [NM];
    logic [DW-1:0] out_data  [NM];
    logic          out_last  [NM];
    logic          w_rd      [NM];
    logic [AW-1:0] w_addr    [NM];
    logic [DW-1:0] w_data    [NM];
    logic          busy      [NM];
    logic          ovf       [NM];

    logic [DW-1:0] in_vec [N_IN];
    logic [DW-1:0] rom    [16];

    int errors = 0;
    int checks = 0;
    bit ovf_exp = 0;

    for (genvar j = 0; j < NM; j++) begin : g_dut
        dense_serial #(
            .N_IN (N_IN),
            .N_OUT(N_OUT),
            .DW   (DW),
            .FRAC (FRAC),
            .ACT  (j),
            .AW   (AW)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready[j]),
            .in_data  (in_data),
            .out_valid(out_valid[j]),
            .out_ready(out_ready),
            .out_data (out_data[j]),
            .out_last (out_last[j]),
            .w_rd     (w_rd[j]),
            .w_addr   (w_addr[j]),
            .w_data   (w_data[j]),
            .busy     (busy[j]),
            .ovf      (ovf[j])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous weight ROM per instance: data one cycle after the read strobe.
    always @(posedge clk) begin
        for (int j = 0; j < NM; j++)
            if (w_rd[j]) w_data[j] <= rom[w_addr[j]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product, floor rescale, saturate, then the mode's clamp rules.
    function automatic logic [DW-1:0] model(input int o, input int mode, output bit sat);
        longint acc;
        longint r;
        longint one;
        int     base;
        one  = longint'(1) << FRAC;
        base = o * (N_IN + 1);
        acc  = 0;
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(in_vec[i])) * longint'($signed(rom[base + i]));
        acc += longint'($signed(rom[base + N_IN])) * one;
        r   = acc >>> FRAC;
        sat = 1'b0;
        if (r > 32767) begin
            r = 32767;  sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; sat = 1'b1;
        end
        case (mode)
            1: if (r < 0) r = 0;
            2: begin
                r = (r >>> 2) + one / 2;
                if (r < 0) r = 0;
                else if (r > one) r = one;
            end
            3: begin
                if (r < -one) r = -one;
                else if (r > one) r = one;
            end
            default: ;
        endcase
        return DW'(r);
    endfunction

    task automatic set_frame(input int xv, input int wv, input int bv);
        for (int k = 0; k < N_IN; k++) in_vec[k] = DW'(xv);
        for (int a = 0; a < 16; a++) rom[a] = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) rom[o * (N_IN + 1) + i] = DW'(wv);
            rom[o * (N_IN + 1) + N_IN] = DW'(bv);
        end
    endtask

    task automatic set_random(input int span);
        for (int k = 0; k < N_IN; k++)
            in_vec[k] = (span == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 2 * span - 1)) - span);
        for (int a = 0; a < 16; a++)
            rom[a] = (span == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 2 * span - 1)) - span);
    endtask

    task automatic feed_inputs();
        for (int k = 0; k < N_IN; k++) begin
            in_valid = 1'b1;
            in_data  = in_vec[k];
            check("in_ready_load", 64'(in_ready[0]), 64'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("in_ready_fall", 64'(in_ready[0]), 64'(0));
        check("w_rd_mac0", 64'(w_rd[0]), 64'(1));
    endtask

    // One full frame; optionally stall output stall_o for 10 cycles and toggle in_valid while busy.
    task automatic do_frame(input int stall_o, input bit noise);
        bit            sat;
        int            cyc;
        logic [DW-1:0] exp_d [NM];
        feed_inputs();
        if (noise) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
        end
        for (int o = 0; o < N_OUT; o++) begin
            cyc = 0;
            while (!out_valid[0] && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("latency", 64'(cyc), 64'(N_IN + 3));
            check("out_valid", 64'(out_valid[0]), 64'(1));
            for (int j = 0; j < NM; j++) begin
                exp_d[j] = model(o, j, sat);
                if (sat) ovf_exp = 1'b1;
                check($sformatf("data_o%0d_act%0d", o, j), 64'(out_data[j]), 64'(exp_d[j]));
            end
            check("out_last", 64'(out_last[0]), 64'(o == N_OUT - 1));
            if (o == stall_o) begin
                repeat (10) begin
                    @(posedge clk); #1;
                    check("stall_valid", 64'(out_valid[0]), 64'(1));
                    check("stall_data", 64'(out_data[0]), 64'(exp_d[0]));
                    check("stall_w_rd", 64'(w_rd[0]), 64'(0));
                    check("stall_in_ready", 64'(in_ready[0]), 64'(0));
                end
            end
            if (o == N_OUT - 1) in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        for (int j = 0; j < NM; j++)
            check($sformatf("ovf_act%0d", j), 64'(ovf[j]), 64'(ovf_exp));
        check("in_ready_end", 64'(in_ready[0]), 64'(1));
        check("busy_end", 64'(busy[0]), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int j = 0; j < NM; j++) begin
            check({tag, "_in_ready"},  64'(in_ready[j]),  64'(1));
            check({tag, "_out_valid"}, 64'(out_valid[j]), 64'(0));
            check({tag, "_out_data"},  64'(out_data[j]),  64'(0));
            check({tag, "_out_last"},  64'(out_last[j]),  64'(0));
            check({tag, "_w_rd"},      64'(w_rd[j]),      64'(0));
            check({tag, "_w_addr"},    64'(w_addr[j]),    64'(0));
            check({tag, "_busy"},      64'(busy[j]),      64'(0));
            check({tag, "_ovf"},       64'(ovf[j]),       64'(0));
        end
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        set_frame(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset");

        // Directed vectors: positive, negative, saturating, then clean frame with stall and noise.
        set_frame(256, 128, 64);
        do_frame(-1, 1'b0);
        set_frame(256, -128, 64);
        do_frame(-1, 1'b0);
        set_frame(32512, 32512, 0);
        do_frame(-1, 1'b0);
        set_frame(256, 128, 64);
        do_frame(0, 1'b1);

        // Reset while output 1 is in MAC.
        feed_inputs();
        cyc = 0;
        while (!out_valid[0] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("pre_rst_valid", 64'(out_valid[0]), 64'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_mac", 64'(w_rd[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        ovf_exp = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_idle", 64'(out_valid[0]), 64'(0));
        end
        set_frame(256, -128, 64);
        do_frame(-1, 1'b0);

        // Randomised frames: moderate ranges, then full-scale values that may saturate.
        for (int r = 0; r < 4; r++) begin
            set_random(2048);
            do_frame((r == 1) ? 1 : -1, r[0]);
        end
        for (int r = 0; r < 2; r++) begin
            set_random(0);
            do_frame(-1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
